// File: rtl/fetch_pkg.sv
// Shared fetch front-end types, reset/exception vectors and supervisor-preserving PC arithmetic.
package fetch_pkg;

  localparam logic [31:0] START_VEC = 32'h0000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  localparam int unsigned PC_MAX_W = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fifo_entry_t;

  // +4 on the low w-1 bits only; bit w-1 (supervisor) passes through untouched.
  function automatic logic [PC_MAX_W-1:0] pc_inc(input logic [PC_MAX_W-1:0] pc,
                                                 input int unsigned w);
    logic [PC_MAX_W-1:0] low_mask;
    low_mask = (PC_MAX_W'(1) << (w - 1)) - PC_MAX_W'(1);
    return (pc & ~low_mask) | ((pc + PC_MAX_W'(4)) & low_mask);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; flush empties it in a single cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = count_q == (PW+1)'(DEPTH);
    empty    = count_q == '0;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: PC generator, credited imem request stream and prefetch FIFO feeding ID.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/dropped performance counters.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_VEC),
  parameter logic [ADDR_W-1:0] ILLOP_ADDR = ADDR_W'(ILLOP_VEC),
  parameter logic [ADDR_W-1:0] XADR_ADDR  = ADDR_W'(XADR_VEC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              exc_valid,
  input  logic              exc_sel,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc4,
  input  logic              id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fpc_q, fpc_d, rpc_q, rpc_d, flush_target;
  logic [CW-1:0]     outstanding_q, outstanding_d, drop_q, drop_d, fifo_count;
  logic              flush, grant, drop_active;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  entry_t            push_entry, head_entry;

  function automatic logic [ADDR_W-1:0] inc4(input logic [ADDR_W-1:0] pc);
    return ADDR_W'(pc_inc(PC_MAX_W'(pc), ADDR_W));
  endfunction

  always_comb begin
    flush        = exc_valid || redirect_valid;
    flush_target = exc_valid ? (exc_sel ? XADR_ADDR : ILLOP_ADDR) : redirect_pc;
    // Requests in flight plus buffered words never exceed the FIFO, so a push always fits.
    imem_req     = reset && !flush && !fifo_full &&
                   ((CW+1)'(outstanding_q) + (CW+1)'(fifo_count) < (CW+1)'(FIFO_DEPTH));
    imem_addr    = fpc_q;
    grant        = imem_req && imem_gnt;
    drop_active  = drop_q != '0;
    fifo_push    = imem_rvalid && !drop_active && !flush;
    fifo_pop     = id_valid && id_ready && !flush;
    push_entry   = '{instr: imem_rdata, pc: rpc_q};

    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    drop_d        = drop_q;
    fpc_d         = fpc_q;
    rpc_d         = rpc_q;
    if (flush) begin
      // Everything still in flight after this cycle's response belongs to the old stream.
      drop_d = outstanding_q - CW'(imem_rvalid);
      fpc_d  = flush_target;
      rpc_d  = flush_target;
    end else begin
      if (imem_rvalid && drop_active) drop_d = drop_q - CW'(1);
      if (grant)                      fpc_d  = inc4(fpc_q);
      if (fifo_push)                  rpc_d  = inc4(rpc_q);
    end

    id_valid = !fifo_empty;
    id_instr = fifo_empty ? '0 : head_entry.instr;
    id_pc    = fifo_empty ? '0 : head_entry.pc;
    id_pc4   = fifo_empty ? '0 : inc4(head_entry.pc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q         <= START_ADDR;
      rpc_q         <= START_ADDR;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fpc_q         <= fpc_d;
      rpc_q         <= rpc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (flush),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d, dropped_q, dropped_d;
  logic [32:0] dropped_sum;

  always_comb begin
    fetched_d   = (fifo_pop && fetched_q != '1) ? fetched_q + 32'd1 : fetched_q;
    dropped_sum = {1'b0, dropped_q} + (flush ? 33'(fifo_count) : 33'd0)
                + 33'(imem_rvalid && (drop_active || flush));
    dropped_d   = dropped_sum[32] ? '1 : dropped_sum[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      dropped_q <= dropped_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, corner sequences and a random run against a queue-based model.
`timescale 1ns/1ps
module tb_ifetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, exc_valid, exc_sel;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  always #5 clk = ~clk;

  ifetch_queue #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .exc_sel        (exc_sel),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .id_ready       (id_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] nxt(logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  function automatic logic [31:0] mdata(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  // Bench memory: in-order responses, per-request latency in [lat_min, lat_max].
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    last_due = 0;
  int    lat_min = 1, lat_max = 1;

  // Reference model: in-flight fetch addresses (stale after a flush) and the ID-bound queue.
  typedef struct { logic [31:0] addr; bit stale; } inflight_t;
  inflight_t   m_inf[$];
  fifo_entry_t m_fifo[$];
  logic [31:0] m_fpc;
  int unsigned m_fetched, m_dropped;
  logic        last_grant;

  // A push while the FIFO is full would mean the credit rule was broken.
  always @(negedge clk) begin
    if (reset && dut.fifo_push) begin
      n_vec++;
      if (dut.fifo_full) begin
        n_err++;
        $display("FAIL push_into_full: push=1 full=1 required full=0 (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect_valid = 0; redirect_pc = '0; exc_valid = 0; exc_sel = 0; id_ready = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    #1;
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_pc4", id_pc4, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 0);
    chk("rst_perf_dropped", perf_dropped, 0);
`endif
    mq.delete(); m_inf.delete(); m_fifo.delete();
    m_fpc = 32'h0; m_fetched = 0; m_dropped = 0;
    @(posedge clk); #1; cyc++;
    last_due = cyc;
    reset = 1;
  endtask

  task automatic step(input logic gnt, input logic rdy, input logic redir,
                      input logic [31:0] rpc, input logic exc, input logic esel);
    logic        flush, exp_req, rv, pop;
    logic [31:0] pc4_exp;
    fifo_entry_t hd;
    inflight_t   f;
    int          due;
    imem_gnt = gnt; id_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    exc_valid = exc; exc_sel = esel;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata = '0;
    if (rv) imem_rdata = mdata(mq[0].addr);
    @(negedge clk);
    flush   = redir || exc;
    exp_req = ((m_inf.size() + m_fifo.size()) < DEPTH) && !flush;
    hd      = '0;
    pc4_exp = '0;
    if (m_fifo.size() > 0) begin
      hd      = m_fifo[0];
      pc4_exp = nxt(hd.pc);
    end
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, m_fpc);
    chk("id_valid", 32'(id_valid), 32'(m_fifo.size() > 0));
    chk("id_pc", id_pc, hd.pc);
    chk("id_instr", id_instr, hd.instr);
    chk("id_pc4", id_pc4, pc4_exp);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_dropped", perf_dropped, m_dropped);
`endif
    last_grant = imem_req && gnt;
    if (rv) void'(mq.pop_front());
    if (last_grant) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      mq.push_back('{imem_addr, due});
      last_due = due;
    end
    pop = !flush && (m_fifo.size() > 0) && rdy;
    if (pop) begin
      void'(m_fifo.pop_front());
      m_fetched++;
    end
    if (rv && m_inf.size() > 0) begin
      f = m_inf.pop_front();
      if (f.stale || flush) m_dropped++;
      else m_fifo.push_back('{instr: mdata(f.addr), pc: f.addr});
    end
    if (flush) begin
      m_dropped += m_fifo.size();
      m_fifo.delete();
      for (int unsigned i = 0; i < m_inf.size(); i++) m_inf[i].stale = 1;
      m_fpc = exc ? (esel ? 32'h8000_0008 : 32'h8000_0004) : rpc;
    end else if (exp_req && gnt) begin
      m_inf.push_back('{m_fpc, 1'b0});
      m_fpc = nxt(m_fpc);
    end
    @(posedge clk); #1; cyc++;
  endtask

  typedef struct {
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        exc, esel, rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_pc, e_pc4, e_instr;
  } vec_t;

  function automatic vec_t mkv(logic gnt, logic rv, logic [31:0] rdata, logic redir,
                               logic [31:0] rpc, logic exc, logic esel, logic rdy,
                               logic e_req, logic [31:0] e_addr, logic e_idv,
                               logic [31:0] e_pc, logic [31:0] e_pc4, logic [31:0] e_instr);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.redir = redir; v.rpc = rpc;
    v.exc = exc; v.esel = esel; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_idv = e_idv; v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int grants;
    int found;
    logic [31:0] d0;
    idle_inputs();
    d0 = '0;

    // Directed table: 1-cycle memory driven by hand, redirect, exc over redirect, kernel wrap.
    tbl[0]  = mkv(1,0,32'h0,         0,32'h0,        0,0,1, 1,32'h0000_0000, 0,32'h0,32'h0,32'h0);
    tbl[1]  = mkv(1,1,32'h1111_0000, 0,32'h0,        0,0,1, 1,32'h0000_0004, 0,32'h0,32'h0,32'h0);
    tbl[2]  = mkv(1,1,32'h1111_0004, 0,32'h0,        0,0,1, 1,32'h0000_0008, 1,32'h0,32'h4,32'h1111_0000);
    tbl[3]  = mkv(0,1,32'h1111_0008, 0,32'h0,        0,0,1, 1,32'h0000_000C, 1,32'h4,32'h8,32'h1111_0004);
    tbl[4]  = mkv(0,0,32'h0,         0,32'h0,        0,0,1, 1,32'h0000_000C, 1,32'h8,32'hC,32'h1111_0008);
    tbl[5]  = mkv(0,0,32'h0,         1,32'h100,      0,0,1, 0,32'h0000_000C, 0,32'h0,32'h0,32'h0);
    tbl[6]  = mkv(1,0,32'h0,         0,32'h0,        0,0,1, 1,32'h0000_0100, 0,32'h0,32'h0,32'h0);
    tbl[7]  = mkv(0,1,32'h2222_0100, 0,32'h0,        0,0,1, 1,32'h0000_0104, 0,32'h0,32'h0,32'h0);
    tbl[8]  = mkv(0,0,32'h0,         1,32'h200,      1,1,0, 0,32'h0000_0104, 1,32'h100,32'h104,32'h2222_0100);
    tbl[9]  = mkv(1,0,32'h0,         0,32'h0,        0,0,0, 1,32'h8000_0008, 0,32'h0,32'h0,32'h0);
    tbl[10] = mkv(0,1,32'h3333_0008, 0,32'h0,        0,0,0, 1,32'h8000_000C, 0,32'h0,32'h0,32'h0);
    tbl[11] = mkv(0,0,32'h0,         1,32'hFFFF_FFFC,0,0,0, 0,32'h8000_000C, 1,32'h8000_0008,32'h8000_000C,32'h3333_0008);
    tbl[12] = mkv(1,0,32'h0,         0,32'h0,        0,0,1, 1,32'hFFFF_FFFC, 0,32'h0,32'h0,32'h0);
    tbl[13] = mkv(0,1,32'h4444_FFFC, 0,32'h0,        0,0,1, 1,32'h8000_0000, 0,32'h0,32'h0,32'h0);
    tbl[14] = mkv(0,0,32'h0,         0,32'h0,        0,0,1, 1,32'h8000_0000, 1,32'hFFFF_FFFC,32'h8000_0000,32'h4444_FFFC);
    tbl[15] = mkv(0,0,32'h0,         0,32'h0,        0,0,1, 1,32'h8000_0000, 0,32'h0,32'h0,32'h0);

    #2;
    do_reset();
    for (int unsigned i = 0; i < 16; i++) begin
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
      exc_valid = tbl[i].exc; exc_sel = tbl[i].esel; id_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_idv", i), 32'(id_valid), 32'(tbl[i].e_idv));
      chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_pc4", i), id_pc4, tbl[i].e_pc4);
      chk($sformatf("tbl%0d_instr", i), id_instr, tbl[i].e_instr);
      @(posedge clk); #1; cyc++;
    end

    // ID stalled: credit must stop requests after exactly DEPTH grants, head holds 0x0.
    do_reset();
    lat_min = 1; lat_max = 1;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 32'h0, 0, 0);
      grants += int'(last_grant);
    end
    chk("stall_grants", 32'(grants), DEPTH);
    chk("stall_req_off", 32'(imem_req), 0);
    chk("stall_hold_pc", id_pc, 32'h0);
    chk("stall_hold_valid", 32'(id_valid), 1);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 32'h0, 0, 0);

    // 3-cycle memory, two requests in flight, then redirect: both stale words dropped.
    do_reset();
    lat_min = 3; lat_max = 3;
    step(1, 1, 0, 32'h0, 0, 0);
    step(1, 1, 0, 32'h0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    d0 = perf_dropped;
`endif
    step(0, 1, 1, 32'h100, 0, 0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (id_valid) begin
        found = 1;
        chk("redir_first_pc", id_pc, 32'h100);
      end else begin
        step(1, 0, 0, 32'h0, 0, 0);
      end
    end
    chk("redir_seen", 32'(found), 1);
`ifdef FETCH_PERF_CNT_EN
    chk("redir_perf_dropped", perf_dropped - d0, 2);
`endif
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h0, 0, 0);

    // Reset mid-burst with requests outstanding; fetch must restart at START_ADDR.
    step(1, 1, 0, 32'h0, 0, 0);
    step(1, 1, 0, 32'h0, 0, 0);
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h0, 0, 0);

    // Random traffic with variable latency against the model.
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic r, e;
      r = ($urandom_range(15, 0) == 0);
      e = ($urandom_range(31, 0) == 0);
      step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, r,
           $urandom & 32'hFFFF_FFFC, e, 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
